mixer_nch: RTL and testbench

N-channel, parametrised-width successor of the two-input audio mixer: folds up to N offset-binary voice samples into one output sample with the pairwise non-linear mixing law. One shared multiplier is time-multiplexed across channels, with per-channel enables and a selectable mixing law (legacy single-branch or two-branch). Output saturates to full scale. Sits between the voice generators and the output DAC stage, running one frame per audio sample under valid/ready handshakes.

---
 rtl/mixer_nch.sv | 117 +++++++++++
 tb/tb_mixer_nch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_nch.sv
// N-channel offset-binary audio mixer: folds up to N voice samples through the
// pairwise non-linear mixing law using one time-multiplexed multiplier.
module mixer_nch #(
  parameter int W = 18,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     ch_en,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W+3:0] FULL = {4'b0001, {W{1'b0}}};
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, MUL, ADD, OUT} state_t;

  state_t                 state;
  logic [N*W-1:0]         data_q;
  logic [N-1:0]           en_q;
  logic                   mode_q;
  logic [W-1:0]           acc;
  logic [IW-1:0]          idx;
  logic [2*W-1:0]         prod;

  logic [W-1:0]           x;
  logic [W:0]             q;
  logic signed [W+3:0]    r_lin;
  logic signed [W+3:0]    r;
  logic                   low_both;
  logic [W-1:0]           mixed;
  logic [W-1:0]           acc_next;

  assign x = data_q[idx*W +: W];
  assign q = prod[2*W-1:W-1];

  // Mixing law on the running accumulator and the current channel, clamped to full scale
  always_comb begin
    r_lin    = ($signed({4'b0, acc}) <<< 1) + ($signed({4'b0, x}) <<< 1)
             - $signed({3'b0, q}) - FULL;
    low_both = mode_q && !acc[W-1] && !x[W-1];
    r        = low_both ? $signed({3'b0, q}) : r_lin;
    if (r[W+3])
      mixed = '0;
    else if (r >= FULL)
      mixed = '1;
    else
      mixed = r[W-1:0];
    acc_next = en_q[idx] ? mixed : acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= MID;
      acc       <= MID;
      idx       <= '0;
      prod      <= '0;
      data_q    <= '0;
      en_q      <= '0;
      mode_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            en_q     <= ch_en;
            mode_q   <= mode;
            acc      <= MID;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          // Sole multiplier in the block; disabled channels still pay the cycle
          prod  <= {{W{1'b0}}, acc} * {{W{1'b0}}, x};
          state <= ADD;
        end
        ADD: begin
          acc <= acc_next;
          if (idx == LAST) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= OUT;
          end else begin
            idx   <= idx + IW'(1);
            state <= MUL;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mixer_nch.sv
// Scoreboard bench for mixer_nch (W=18, N=4): directed law/saturation/reset/
// backpressure frames followed by randomly handshaked frames against a model.
module tb_mixer_nch;

  localparam int W = 18;
  localparam int N = 4;
  localparam longint MID = 131072;
  localparam int NF = 1000;
  localparam int BUDGET = 80000;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   ch_en;
  logic           mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_edge = 0;
  longint expq[$];

  mixer_nch #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ch_en(ch_en), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic longint mixModel(input longint a, input longint b, input bit md);
    longint p, q, r;
    p = a * b;
    q = p / 131072;
    if (md && a < MID && b < MID)
      r = q;
    else
      r = 2 * a + 2 * b - q - 262144;
    if (r < 0) r = 0;
    else if (r > 262143) r = 262143;
    return r;
  endfunction

  function automatic longint frameModel(input logic [N*W-1:0] d, input logic [N-1:0] en, input bit md);
    longint acc;
    acc = MID;
    for (int i = 0; i < N; i++)
      if (en[i]) acc = mixModel(acc, longint'(d[i*W +: W]), md);
    return acc;
  endfunction

  function automatic logic [N*W-1:0] pack4(input longint x0, input longint x1,
                                            input longint x2, input longint x3);
    logic [N*W-1:0] d;
    d[0*W +: W] = W'(x0);
    d[1*W +: W] = W'(x1);
    d[2*W +: W] = W'(x2);
    d[3*W +: W] = W'(x3);
    return d;
  endfunction

  function automatic logic [N*W-1:0] randData();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 7))
        0:       d[i*W +: W] = '0;
        1:       d[i*W +: W] = '1;
        2:       d[i*W +: W] = W'(MID);
        default: d[i*W +: W] = W'($urandom_range(0, 262143));
      endcase
    end
    return d;
  endfunction

  // Present one frame, wait (bounded) for acceptance, record the expected result
  task automatic applyStimulus(input logic [N*W-1:0] d, input logic [N-1:0] en, input bit md);
    int n;
    @(negedge clk);
    in_data  = d;
    ch_en    = en;
    mode     = md;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    expq.push_back(frameModel(d, en, md));
    accept_edge = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = randData();
    ch_en    = 4'($urandom);
    mode     = 1'($urandom);
  endtask

  task automatic collectOutput(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checkOutput({tag, "_timeout"}, 0, 1);
      return;
    end
    checkOutput({tag, "_latency"}, cyc - accept_edge, 2 * N);
    if (expq.size() == 0)
      checkOutput({tag, "_unexpected"}, 1, 0);
    else
      checkOutput(tag, out_data, expq.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int sent;
    int recv;
    int budget;
    longint exp_a;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ch_en     = '0;
    mode      = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_data", out_data, MID);
    rst = 1'b1;

    // Reset in the middle of a frame
    applyStimulus(pack4(1000, 2000, 3000, 4000), 4'hF, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("mid_busy", busy, 1);
    checkOutput("mid_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_out_data", out_data, MID);
    expq.delete();
    @(negedge clk);
    rst = 1'b1;

    // Reset while holding a result in OUT
    out_ready = 1'b0;
    applyStimulus(pack4(200000, 100, 50000, 7), 4'hF, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("out_rst_pre_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("out_rst_out_valid", out_valid, 0);
    checkOutput("out_rst_out_data", out_data, MID);
    checkOutput("out_rst_in_ready", in_ready, 1);
    expq.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;

    // All channels disabled, identity, law select and saturation
    applyStimulus(pack4(1, 2, 3, 4), 4'b0000, 1'b0);
    collectOutput("all_off");
    applyStimulus(pack4(200000, 7, 250000, 99), 4'b0001, 1'b0);
    collectOutput("ident_m0");
    applyStimulus(pack4(200000, 7, 250000, 99), 4'b0001, 1'b1);
    collectOutput("ident_m1");
    applyStimulus(pack4(12345, 262143, 5, 0), 4'b0100, 1'b0);
    collectOutput("ident_ch2");
    applyStimulus(pack4(65536, 65536, 9, 9), 4'b0011, 1'b1);
    if (expq.size() > 0) checkOutput("model_law1", expq[expq.size()-1], 32768);
    collectOutput("law_m1");
    applyStimulus(pack4(65536, 65536, 9, 9), 4'b0011, 1'b0);
    if (expq.size() > 0) checkOutput("model_law0", expq[expq.size()-1], 0);
    collectOutput("law_m0");
    applyStimulus(pack4(262143, 262143, 0, 0), 4'b0011, 1'b0);
    if (expq.size() > 0) checkOutput("model_sat", expq[expq.size()-1], 262143);
    collectOutput("sat");

    // Backpressure: result held, second frame waits for the handshake
    out_ready = 1'b0;
    applyStimulus(pack4(30000, 150000, 240000, 131072), 4'b1111, 1'b1);
    exp_a = frameModel(pack4(30000, 150000, 240000, 131072), 4'b1111, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_data  = pack4(70000, 10, 262000, 131000);
    ch_en    = 4'b1011;
    mode     = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checkOutput("bp_data", out_data, exp_a);
      checkOutput("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    checkOutput("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    if (expq.size() == 0)
      checkOutput("bp_first_unexpected", 1, 0);
    else
      checkOutput("bp_first", out_data, expq.pop_front());
    @(negedge clk);
    checkOutput("bp_after_in_ready", in_ready, 1);
    checkOutput("bp_after_out_valid", out_valid, 0);
    expq.push_back(frameModel(in_data, ch_en, mode));
    accept_edge = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = randData();
    checkOutput("bp_second_busy", busy, 1);
    checkOutput("bp_second_in_ready", in_ready, 0);
    collectOutput("bp_second");

    // Random frames with random valid/ready activity
    sent = 0;
    recv = 0;
    budget = 0;
    while ((sent < NF || expq.size() > 0 || out_valid) && budget < BUDGET) begin
      in_data   = randData();
      ch_en     = 4'($urandom);
      mode      = 1'($urandom);
      in_valid  = (sent < NF) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        expq.push_back(frameModel(in_data, ch_en, mode));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0)
          checkOutput("rand_duplicate", 1, 0);
        else
          checkOutput("rand_data", out_data, expq.pop_front());
        recv++;
      end
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0;
    checkOutput("rand_budget", (budget < BUDGET) ? 1 : 0, 1);
    checkOutput("rand_sent", sent, NF);
    checkOutput("rand_recv", recv, NF);
    checkOutput("rand_leftover", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
